alu_issue_ctrl: RTL
===================

# alu_issue_ctrl

Issue controller for the 8-bit ALU. Accepts 18-bit instructions from a requester through a small FIFO, drives them one at a time onto the ALU `instr`/`check` inputs, and waits the fixed ALU latency: single-cycle ops use ALU_LAT and multiply (opcode 110) uses MUL_LAT. It then captures `Y`/`overflow`/`Cout` into a result register with a valid/ready handshake. This replaces hand-timed `check` pulsing and removes the need for requesters to know multiply latency.

## Interface
- DEPTH, 4, instruction FIFO entries; power of 2, ≥2
- ALU_LAT, 1, cycles from issue to result capture for non-multiply ops; ≥1
- MUL_LAT, 11, cycles from issue to result capture for multiply; must be > CHECK_CYC
- CHECK_CYC, 2, cycles `alu_check` is held high at multiply issue; ≥1
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  requester presents instruction
- in_ready  out  1  FIFO can accept; reset 0 while reset is asserted, 1 after
- in_instr  in  18  instruction; opcode = in_instr[17:15]
- alu_instr  out  18  to ALU `instr`; reset 0
- alu_check  out  1  to ALU `check`; reset 0
- alu_Y  in  16  from ALU `Y`
- alu_overflow  in  1  from ALU `overflow`
- alu_Cout  in  1  from ALU `Cout`
- res_valid  out  1  result held; reset 0
- res_ready  in  1  consumer accepts result
- res_Y  out  16  captured Y; reset 0
- res_overflow  out  1  captured overflow; reset 0
- res_Cout  out  1  captured Cout; reset 0
- res_op  out  3  opcode of the captured result; reset 0
- busy  out  1  FSM not IDLE or FIFO non-empty; reset 0

## Operation
- FIFO: circular, with log2(DEPTH)+1-bit count.
  - Push on `in_valid && in_ready`.
  - `in_ready = (count != DEPTH)`, derived from count only. When full, no push occurs even if a pop happens in the same cycle.
  - Push and pop in the same cycle leave count unchanged.
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - If FIFO non-empty: pop head into `alu_instr`, load `cnt` = MUL_LAT if opcode==110, else ALU_LAT, and go to EXEC.
  - If the popped op is a multiply, also load `chk_cnt` = CHECK_CYC and assert `alu_check`.
- EXEC:
  - Decrement `cnt` each cycle.
  - `alu_check` stays high while `chk_cnt` > 0; `chk_cnt` decrements each cycle.
  - When `cnt`==1, capture `alu_Y`/`alu_overflow`/`alu_Cout` and `alu_instr[17:15]` into the res_* registers, set `res_valid`, and go to DONE.
- DONE:
  - Hold `res_*` and `res_valid` stable until `res_ready`.
  - On `res_valid && res_ready`: clear `res_valid` and go to IDLE. The next issue occurs at the following edge at the earliest.
- `alu_instr` stays stable from issue until the next issue; it is never changed during EXEC or DONE.
- Opcodes other than 110, including 111, are treated as single-cycle. The controller never inspects operand fields.
- Only one instruction is in flight. No reordering; results leave in push order.
- Reset asserted mid-EXEC or mid-DONE:
  - Immediately: FIFO emptied, FSM to IDLE, and `alu_check`/`res_valid`/`busy` low.
  - The in-flight result is discarded.

## Timing
- Push at edge p into an empty FIFO while IDLE: issue at edge p+1. `alu_instr` is valid from p+1.
- Multiply issued at edge k: `alu_check` is high for cycles following edges k … k+CHECK_CYC−1, and low from edge k+CHECK_CYC.
- Capture at edge k+LAT, where LAT = ALU_LAT or MUL_LAT; `res_valid` is high from that edge.
  - Defaults: non-multiply result 2 edges after push; multiply result 12 edges after push.
- Handshake at edge h: `res_valid` is low after h. A queued instruction issues at h+1.
- Throughput with `res_ready` tied high:
  - one non-multiply per ALU_LAT+2 cycles;
  - one multiply per MUL_LAT+2 cycles.
- All outputs are registered; no combinational path from inputs to outputs except through `in_ready`, which depends on count only.
- `reset` deassertion must be synchronous to `clock` externally. The first push is accepted at the first edge after deassertion.

## Test plan
- Reset/idle: assert reset mid-simulation with the FIFO holding 3 entries and a multiply in EXEC → all outputs 0 immediately. After release, `in_ready`=1, `busy`=0, and no issue occurs.
- Single-cycle op: push 18'b001010100010101010 into an empty FIFO, with a stub ALU driving `alu_Y`=16'h00AA. Required response:
  - `alu_instr` equals the pushed value one edge later and `alu_check` stays 0;
  - `res_valid` is high 2 edges after the push with `res_Y`=16'h00AA and `res_op`=3'b001.
- Multiply: push 18'b110000100000001000 with the stub ALU changing `alu_Y` to 16'h0008 only at the 11th cycle after issue. Required response:
  - `alu_check` high for exactly 2 cycles;
  - `res_valid` high 12 edges after the push with `res_Y`=16'h0008 and `res_op`=3'b110.
- Back-pressure/full: hold `res_ready`=0 and push 5 ops back-to-back with DEPTH=4. Required response:
  - the 1st op issues and reaches DONE;
  - `in_ready` drops once 4 are queued, so the 6th push is refused;
  - raise `res_ready` → results emerge in push order, each held stable until accepted.
- Mixed stream: interleave 3 single-cycle ops with 2 multiplies and keep `res_ready` high → the issue and capture edges match the latency formulas exactly. `alu_instr` never changes during EXEC.
- Simultaneous push/pop: push on the same edge the FIFO pops at count=1 → count stays 1 and the entry is issued next.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the 8-bit ALU: queues instructions, issues them one at a time,
// waits the fixed ALU latency and presents the captured result on a valid/ready port.
module alu_issue_ctrl #(
    parameter int DEPTH     = 4,
    parameter int ALU_LAT   = 1,
    parameter int MUL_LAT   = 11,
    parameter int CHECK_CYC = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [17:0] in_instr,
    output logic [17:0] alu_instr,
    output logic        alu_check,
    input  logic [15:0] alu_Y,
    input  logic        alu_overflow,
    input  logic        alu_Cout,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_Y,
    output logic        res_overflow,
    output logic        res_Cout,
    output logic [2:0]  res_op,
    output logic        busy
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LAT_MAX = (MUL_LAT > ALU_LAT) ? MUL_LAT : ALU_LAT;
    localparam int CNT_W   = $clog2(LAT_MAX + 1);
    localparam int CHK_W   = $clog2(CHECK_CYC + 1);

    localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] MUL_CNT   = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] ALU_CNT   = CNT_W'(ALU_LAT);
    localparam logic [CHK_W-1:0] CHK_INIT  = CHK_W'(CHECK_CYC);
    localparam logic [2:0]       OP_MUL    = 3'b110;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t            state, state_next;
    logic [17:0]       mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [PTR_W:0]    count, count_next;
    logic [CNT_W-1:0]  cnt;
    logic [CHK_W-1:0]  chk_cnt;
    logic [17:0]       head;
    logic              head_is_mul;
    logic              push, pop, capture, accept;

    // Full check looks at count only, so a pop in the same cycle never frees a slot early.
    assign in_ready    = !reset && (count != FIFO_FULL);
    assign push        = in_valid && in_ready;
    assign head        = mem[rd_ptr];
    assign head_is_mul = (head[17:15] == OP_MUL);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_next = state;
        pop        = 1'b0;
        capture    = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: if (count != '0) begin
                pop        = 1'b1;
                state_next = EXEC;
            end
            EXEC: if (cnt == CNT_W'(1)) begin
                capture    = 1'b1;
                state_next = DONE;
            end
            DONE: if (res_ready) begin
                accept     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + (PTR_W + 1)'(1);
            2'b01:   count_next = count - (PTR_W + 1)'(1);
            default: count_next = count;
        endcase
    end

    // NOTE: the storage array has no reset; count and pointers alone decide what is valid.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= in_instr;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            cnt          <= '0;
            chk_cnt      <= '0;
            alu_instr    <= '0;
            alu_check    <= 1'b0;
            res_valid    <= 1'b0;
            res_Y        <= '0;
            res_overflow <= 1'b0;
            res_Cout     <= 1'b0;
            res_op       <= '0;
            busy         <= 1'b0;
        end else begin
            count <= count_next;
            busy  <= (state_next != IDLE) || (count_next != '0);
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);

            if (pop) begin
                rd_ptr    <= rd_ptr + PTR_W'(1);
                alu_instr <= head;
                cnt       <= head_is_mul ? MUL_CNT : ALU_CNT;
                chk_cnt   <= head_is_mul ? CHK_INIT : '0;
                alu_check <= head_is_mul;
            end else if (state == EXEC) begin
                cnt       <= cnt - CNT_W'(1);
                // chk_cnt counts the check cycles still owed, including the current one.
                alu_check <= (chk_cnt > CHK_W'(1));
                if (chk_cnt != '0) chk_cnt <= chk_cnt - CHK_W'(1);
            end

            if (capture) begin
                res_valid    <= 1'b1;
                res_Y        <= alu_Y;
                res_overflow <= alu_overflow;
                res_Cout     <= alu_Cout;
                res_op       <= alu_instr[17:15];
            end else if (accept) begin
                res_valid <= 1'b0;
            end
        end
    end
endmodule
